// File: rtl/health_pkg.sv
// Shared types and constants for the display arbitration logic.
package health_pkg;

  typedef enum logic [1:0] {
    S_PULSE,
    S_REACT,
    S_HOLD,
    S_BLANK
  } sched_state_t;

  localparam logic       SRC_PULSE   = 1'b0;
  localparam logic       SRC_REACT   = 1'b1;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // Which producer a visible state belongs to (HOLD shows reaction data).
  function automatic logic state_src(input sched_state_t s);
    return (s == S_PULSE) ? SRC_PULSE : SRC_REACT;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Saturating tick counter with synchronous clear; clear beats a coincident tick.
module tick_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt
);

  // Count ticks, hold at all-ones, restart on clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the shared seven-segment display between the pulse monitor and
// the reaction timer. Every change of visible source goes through a dark gap.
module display_scheduler
  import health_pkg::*;
#(
  parameter int unsigned DWELL_TICKS = 3000,
  parameter int unsigned HOLD_TICKS  = 5000,
  parameter int unsigned BLANK_TICKS = 100,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode,
  input  logic       auto_en,
  input  logic       rt_busy,
  input  logic       rt_done,
  input  logic [3:0] pd2,
  input  logic [3:0] pd1,
  input  logic [3:0] pd0,
  input  logic [3:0] rd3,
  input  logic [3:0] rd2,
  input  logic [3:0] rd1,
  input  logic [3:0] rd0,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       src,
  output logic       blank
);

  sched_state_t     state_q, state_d;
  sched_state_t     target_q, target_d;
  sched_state_t     view;
  sched_state_t     after_hold;
  logic             pend_q, pend_d;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt;
  logic             dwell_hit, hold_hit, blank_hit;
  sched_state_t     manual_view;

  // A period of n ticks is complete on the cycle whose tick would bring the
  // count to n; this makes a period last exactly n ticks even when ticks are
  // sparse, and exactly n clocks when tick is tied high.
  function automatic logic expired(input logic [CNT_W-1:0] c, input logic t,
                                   input int unsigned n);
    int unsigned sum;
    sum = 32'(c) + 32'(t);
    return sum >= n;
  endfunction

  tick_counter #(
    .CNT_W(CNT_W)
  ) u_tick_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .tick(tick),
    .cnt (cnt)
  );

  assign dwell_hit   = expired(cnt, tick, DWELL_TICKS);
  assign hold_hit    = expired(cnt, tick, HOLD_TICKS);
  assign blank_hit   = expired(cnt, tick, BLANK_TICKS);
  assign manual_view = mode ? S_REACT : S_PULSE;

  // Next-state: pick the desired view by priority, then route through blank
  // whenever the visible source would change.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    view       = state_q;
    after_hold = S_PULSE;
    cnt_clr    = 1'b0;

    case (state_q)
      S_PULSE: begin
        if (rt_busy)                view = S_REACT;
        else if (rt_done || pend_q) view = S_HOLD;
        else if (auto_en)           view = dwell_hit ? S_REACT : S_PULSE;
        else                        view = manual_view;
        if (view != S_PULSE) begin
          state_d  = S_BLANK;
          target_d = view;
          cnt_clr  = 1'b1;
        end
      end

      S_REACT: begin
        if (rt_busy)                view = S_REACT;
        else if (rt_done || pend_q) view = S_HOLD;
        else if (auto_en)           view = dwell_hit ? S_PULSE : S_REACT;
        else                        view = manual_view;
        if (view == S_PULSE) begin
          state_d  = S_BLANK;
          target_d = S_PULSE;
          cnt_clr  = 1'b1;
        end else if (view == S_HOLD) begin
          // Same source: no dark gap needed.
          state_d = S_HOLD;
          cnt_clr = 1'b1;
        end
      end

      S_HOLD: begin
        // Auto-rotate leaves a held result towards the pulse view.
        after_hold = auto_en ? S_PULSE : manual_view;
        if (rt_busy) begin
          state_d = S_REACT;
          cnt_clr = 1'b1;
        end else if (rt_done) begin
          cnt_clr = 1'b1;
        end else if (hold_hit) begin
          cnt_clr = 1'b1;
          if (after_hold == S_REACT) begin
            state_d = S_REACT;
          end else begin
            state_d  = S_BLANK;
            target_d = S_PULSE;
          end
        end
      end

      S_BLANK: begin
        // Retarget freely while dark; the gap length is not restarted.
        if (rt_busy)                view = S_REACT;
        else if (rt_done || pend_q) view = S_HOLD;
        else if (auto_en)           view = target_q;
        else                        view = manual_view;
        target_d = view;
        if (blank_hit) begin
          state_d = view;
          cnt_clr = 1'b1;
        end
      end

      default: begin
        state_d = S_PULSE;
        cnt_clr = 1'b1;
      end
    endcase

    // A finished result waits until the hold view is actually entered.
    pend_d = (state_d == S_HOLD) ? 1'b0 : (pend_q | rt_done);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_PULSE;
      target_q <= S_PULSE;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pend_q   <= pend_d;
    end
  end

  // Registered display outputs follow the state being entered, with producer
  // digits sampled live; src keeps its last value across a dark gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d3    <= BLANK_DIGIT;
      d2    <= BLANK_DIGIT;
      d1    <= BLANK_DIGIT;
      d0    <= BLANK_DIGIT;
      src   <= SRC_PULSE;
      blank <= 1'b1;
    end else begin
      case (state_d)
        S_PULSE: begin
          d3    <= BLANK_DIGIT;
          d2    <= pd2;
          d1    <= pd1;
          d0    <= pd0;
          src   <= state_src(state_d);
          blank <= 1'b0;
        end
        S_REACT, S_HOLD: begin
          d3    <= rd3;
          d2    <= rd2;
          d1    <= rd1;
          d0    <= rd0;
          src   <= state_src(state_d);
          blank <= 1'b0;
        end
        default: begin
          d3    <= BLANK_DIGIT;
          d2    <= BLANK_DIGIT;
          d1    <= BLANK_DIGIT;
          d0    <= BLANK_DIGIT;
          blank <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with short timing parameters.
module tb_display_scheduler;

  logic       clk = 1'b0;
  logic       rst, tick, mode, auto_en, rt_busy, rt_done;
  logic [3:0] pd2, pd1, pd0, rd3, rd2, rd1, rd0;
  logic [3:0] d3, d2, d1, d0;
  logic       src, blank;

  always #5 clk = ~clk;

  display_scheduler #(
    .DWELL_TICKS(4),
    .HOLD_TICKS (6),
    .BLANK_TICKS(2),
    .CNT_W      (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .mode   (mode),
    .auto_en(auto_en),
    .rt_busy(rt_busy),
    .rt_done(rt_done),
    .pd2    (pd2),
    .pd1    (pd1),
    .pd0    (pd0),
    .rd3    (rd3),
    .rd2    (rd2),
    .rd1    (rd1),
    .rd0    (rd0),
    .d3     (d3),
    .d2     (d2),
    .d1     (d1),
    .d0     (d0),
    .src    (src),
    .blank  (blank)
  );

  // Expected words: {d3,d2,d1,d0,src,blank}
  localparam logic [17:0] P  = {16'hF721, 1'b0, 1'b0};
  localparam logic [17:0] R  = {16'h0345, 1'b1, 1'b0};
  localparam logic [17:0] B0 = {16'hFFFF, 1'b0, 1'b1};
  localparam logic [17:0] B1 = {16'hFFFF, 1'b1, 1'b1};

  typedef struct {
    logic [17:0] e;
    int          ph;
    int          idx;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          phase   = 0;
  int          vec     = 0;
  exp_t        cur;
  logic [17:0] got;

  // Push the expectation for the coming edge, then let that edge happen.
  task automatic step(input logic [17:0] e);
    exp_t x;
    x.e   = e;
    x.ph  = phase;
    x.idx = vec;
    vec++;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic rep(input logic [17:0] e, input int n);
    for (int i = 0; i < n; i++) step(e);
  endtask

  // Monitor: compare the registered outputs shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      got = {d3, d2, d1, d0, src, blank};
      n_tests++;
      if (got !== cur.e) begin
        n_fail++;
        $display("FAIL phase%0d vec%0d out: got d=%h src=%b blank=%b, want d=%h src=%b blank=%b",
                 cur.ph, cur.idx, got[17:2], got[1], got[0], cur.e[17:2], cur.e[1], cur.e[0]);
      end
    end
  end

  logic [17:0] auto_seq [14];

  initial begin
    rst = 1'b0; tick = 1'b1; mode = 1'b0; auto_en = 1'b0;
    rt_busy = 1'b0; rt_done = 1'b0;
    pd2 = 4'd7; pd1 = 4'd2; pd0 = 4'd1;
    rd3 = 4'd0; rd2 = 4'd3; rd1 = 4'd4; rd0 = 4'd5;
    auto_seq = '{P, P, B0, B0, R, R, R, R, B1, B1, P, P, P, P};
    @(negedge clk);

    // Reset then release
    phase = 1;
    rep(B0, 3);
    rst = 1'b1;
    rep(P, 2);

    // Manual switch both ways
    phase = 2;
    mode = 1'b1;
    rep(B0, 2);
    rep(R, 2);
    mode = 1'b0;
    rep(B1, 2);
    rep(P, 2);

    // Auto rotation with mode toggling underneath
    phase = 3;
    auto_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      mode = i[0];
      step(auto_seq[i]);
    end
    auto_en = 1'b0;
    mode    = 1'b0;
    step(P);

    // rt_done pre-emption and hold restart
    phase = 4;
    rt_done = 1'b1;
    step(B0);
    rt_done = 1'b0;
    step(B0);
    rep(R, 4);
    rt_done = 1'b1;
    step(R);
    rt_done = 1'b0;
    rep(R, 5);
    rep(B1, 2);
    step(P);

    // Busy and done together; hold follows busy without a gap
    phase = 5;
    rt_busy = 1'b1;
    rt_done = 1'b1;
    step(B0);
    rt_done = 1'b0;
    step(B0);
    rep(R, 2);
    rt_busy = 1'b0;
    rep(R, 6);
    rep(B1, 2);
    step(P);

    // Sparse ticks, then reset in the middle of a gap
    phase = 6;
    mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 10 == 9);
      step((i == 19) ? R : B0);
    end
    mode = 1'b0;
    for (int i = 20; i < 25; i++) begin
      tick = (i % 10 == 9);
      step(B1);
    end
    tick = 1'b0;
    rst  = 1'b0;
    step(B0);
    rst = 1'b1;
    rep(P, 2);

    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Arbitrates the shared 8-digit seven-segment display between the pulse monitor (pd2..pd0) and the reaction timer (rd3..rd0).
- Sits between both producers and display_control. Supplies one registered 4-digit value set plus a source flag and a blank flag.
- Supports manual selection, timed auto-rotation and event pre-emption. Every source change passes through a blank gap.

Parameters:
- DWELL_TICKS, 3000, ticks each source is shown in auto-rotate mode (3 s at 1 kHz tick).
- HOLD_TICKS, 5000, ticks a fresh reaction result is held on the display after rt_done.
- BLANK_TICKS, 100, ticks of blank display inserted on every source change.
- CNT_W, 16, tick counter width; must hold max(DWELL_TICKS, HOLD_TICKS, BLANK_TICKS).

Ports:
- clk  input  1  system clock; the single clock for the block.
- rst  input  1  synchronous, active-low reset.
- tick  input  1  one-cycle enable at 1 kHz from clkdiv; all timing counts tick cycles only.
- mode  input  1  manual select: 0 = pulse, 1 = reaction.
- auto_en  input  1  1 = auto-rotate; mode is ignored.
- rt_busy  input  1  reaction test in progress; forces reaction view.
- rt_done  input  1  one-cycle pulse when a new reaction result is valid.
- pd2, pd1, pd0  input  4 each  pulse-monitor BCD digits.
- rd3, rd2, rd1, rd0  input  4 each  reaction-timer BCD digits.
- d3, d2, d1, d0  output  4 each  digits to display_control.
- src  output  1  0 = pulse shown, 1 = reaction shown (held during blank).
- blank  output  1  1 = display must be dark.

Behaviour:
- Reset (rst = 0 at a clk edge): state = S_PULSE, counter = 0, done_pend = 0, src = 0, blank = 1, d3..d0 = 4'hF.
- States:
  - S_PULSE: shows pulse digits.
  - S_REACT: shows reaction digits.
  - S_HOLD: shows reaction digits for HOLD_TICKS.
  - S_BLANK: shows nothing for BLANK_TICKS; a target register records the state to enter next.
- Desired view, evaluated each cycle in priority order:
  1. rt_busy = 1 → REACT.
  2. rt_done = 1 or done_pend = 1 → HOLD.
  3. auto_en = 1 → rotate when the counter reaches DWELL_TICKS (PULSE↔REACT).
  4. Otherwise mode.
- Source change: if the desired view shows a different source than the current state, go to S_BLANK with target = desired, and clear the counter.
- Same-source change: S_REACT↔S_HOLD involves no source change, so the transition is direct with no blank.
- S_BLANK exit: when the counter reaches BLANK_TICKS, enter target and clear the counter.
- Retargeting in blank: if the desired view changes while in S_BLANK, update target without restarting the counter.
- S_HOLD exit: after HOLD_TICKS go to S_BLANK with target = the non-hold desired view. If that view is REACT, go directly to S_REACT.
- rt_done during S_HOLD: restarts the hold counter.
- rt_done with rt_busy in the same cycle: busy wins and done_pend is set. done_pend is serviced (→ S_HOLD) when rt_busy falls, and is cleared on entry to S_HOLD.
- Counter:
  - Increments only on tick and saturates at 2^CNT_W-1.
  - Clearing on a state change takes precedence over a coincident tick.
- Mode switching: changing auto_en 1→0 takes effect at the next evaluation, with no wait for dwell expiry. Toggling mode while auto_en = 1 has no effect.
- Outputs are registered; latency is 1 clk from the input change to the output.
  - S_PULSE: d3 = 4'hF (blank code), d2..d0 = pd2..pd0.
  - S_REACT and S_HOLD: d3..d0 = rd3..rd0.
  - S_BLANK: blank = 1 and all digits = 4'hF.
  - blank = 0 in every other state.
- Digit inputs are sampled every cycle; the block does no latching of producer data.
- Reset mid-operation returns to the reset values on the next edge, regardless of state.

Decomposition:
- Shared package health_pkg holds:
  - typedef enum logic [1:0] sched_state_t {S_PULSE, S_REACT, S_HOLD, S_BLANK}.
  - localparams SRC_PULSE = 1'b0, SRC_REACT = 1'b1, BLANK_DIGIT = 4'hF.
- One sub-module: tick_counter, a saturating CNT_W counter with clear and tick enable, instantiated once.

Test Plan (DWELL=4, HOLD=6, BLANK=2, tick tied high unless stated):
- Reset: hold rst = 0 for 3 cycles → blank = 1, d = FFFF, src = 0. One cycle after release → S_PULSE, d3 = F, d2..d0 = pd (pd = 7,2,1 → F721).
- Manual switch: mode 0→1 → 2 cycles with blank = 1, then src = 1, d = rd (rd = 0,3,4,5 → 0345). mode back to 0 → blank, then F721.
- Auto rotate: auto_en = 1, mode = 0 → the sequence pulse(4), blank(2), react(4), blank(2) repeats. mode toggles have no effect.
- Pre-emption: rt_done pulse in S_PULSE → blank 2, then S_HOLD for 6 ticks. A second rt_done at hold tick 3 extends the hold to 6 more ticks. Afterwards blank, then pulse.
- Simultaneous events: rt_busy = 1 and rt_done = 1 in the same cycle → S_REACT. When rt_busy drops → S_HOLD directly, with no blank.
- Tick gating: tick every 10th cycle with BLANK=2 → blank lasts exactly 2 ticks. Asserting rst mid-blank → FFFF, then S_PULSE.
